alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-and-issue stage that produces the ALU's control and operand interface: it decodes a MIPS instruction into the 6-bit ALUFun code, the Sign flag and the A/B operands, then registers them into the ID/EX pipeline boundary. Stall and flush are handled here. The ALU in EX consumes these outputs with no further decoding. The block's output is the only source of ALUFun in the pipeline.

## Interface
Parameters:
- `XLEN`, 32, datapath width. Fixed at 32; it exists only so width checks are explicit.

Ports:
- `clk`, in, 1, sole clock.
- `reset`, in, 1, synchronous, active-high.
- `in_valid`, in, 1, an instruction is present at `instr`.
- `instr`, in, 32, instruction word from IF/ID.
- `rs_data`, in, 32, forwarded rs value.
- `rt_data`, in, 32, forwarded rt value.
- `stall`, in, 1, hold every output register.
- `flush`, in, 1, replace the next output with a bubble.
- `ex_valid`, out, 1, registered outputs hold a live instruction.
- `ex_alu_fun`, out, 6, ALUFun code for the ALU.
- `ex_sign`, out, 1, signed compare/overflow select.
- `ex_a`, out, 32, ALU operand A. For shifts this is the shift amount.
- `ex_b`, out, 32, ALU operand B.
- `ex_wr_reg`, out, 5, destination register number.
- `ex_reg_write`, out, 1, result is written back.
- `ex_branch`, out, 1, instruction is a conditional branch.
- `ex_illegal`, out, 1, opcode/funct not supported.

## Operation
ALUFun codes:
- ADD 000000, SUB 000001
- AND 011000, OR 011110, XOR 010110, NOR 010001, PASSA 011010
- SLL 100000, SRL 100001, SRA 100011
- EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111

R-type decode (opcode 0): `ex_wr_reg`=rd.
- add/sub: ADD/SUB, Sign=1. addu/subu: ADD/SUB, Sign=0.
- and/or/xor/nor: logic codes.
- slt: LT, Sign=1. sltu: LT, Sign=0.
- A=rs_data, B=rt_data for all of the above.
- sll/srl/sra: A={27'b0, shamt}, B=rt_data.
- sllv/srlv/srav: A={27'b0, rs_data[4:0]}, B=rt_data.

I-type decode: `ex_wr_reg`=rt.
- addi/slti: sign-extended immediate, Sign=1; codes ADD/LT.
- addiu: sign-extended immediate, Sign=0; code ADD.
- sltiu: sign-extended immediate, Sign=0; code LT.
- andi/ori/xori: zero-extended immediate.
- lui: SLL with A=16, B=zero-extended imm.
- lw/sw: ADD, Sign=1, B=sign-extended imm. `ex_reg_write`=0 for sw.

Branches: `ex_branch`=1, `ex_reg_write`=0, Sign=1.
- beq/bne: EQ/NEQ with A=rs, B=rt.
- blez/bgtz/bltz (REGIMM rt=0): LEZ/GTZ/LTZ with A=rs, B=0.

Other rules:
- Writes to register 0 set `ex_reg_write`=0.
- Unsupported opcode/funct: `ex_illegal`=1, `ex_valid`=1, `ex_reg_write`=0, code ADD, A=B=0.

## Timing
- Latency is 1 cycle: inputs sampled at a rising `clk` appear on `ex_*` after that edge.
- Priority order: `reset` > `flush` > `stall` > load.
- Reset: every output is 0. `ex_alu_fun`=000000.
- Flush, including when `stall` is also high: `ex_valid`=0, `ex_reg_write`=0, `ex_branch`=0, `ex_illegal`=0; other outputs are don't-care and are driven 0.
- Stall without flush: every output keeps its value and inputs are ignored.
- `in_valid`=0 with no stall or flush: a bubble is loaded, identical to the flush case.
- Reset asserted mid-stall clears the stage; the held instruction is lost.
- Operands are captured as presented. Forwarding correctness is upstream.

## Structure
- Package `alu_pkg` holds:
  - the ALUFun localparams listed above;
  - opcode and funct constants;
  - a sign/zero-extend helper function.
- Combinational sub-module `alu_fun_decoder` maps (instr, rs_data, rt_data) to the unregistered control and operand bundle.
- The top level holds only the ID/EX register and the priority logic.

## Test plan
- Reset held for 2 cycles, then `sub $3,$1,$2` with rs=5, rt=7 → next cycle: alu_fun=000001, sign=1, A=5, B=7, wr_reg=3, reg_write=1, valid=1.
- `sra $4,$5,3` with rt=0x80000000 → alu_fun=100011, A=3, B=0x80000000. `lui $6,0x1234` → alu_fun=100000, A=16, B=0x00001234.
- `sltiu $2,$1,-1` → alu_fun=110101, sign=0, B=0xFFFFFFFF. `andi` with imm 0x8000 → B=0x00008000.
- `beq` → alu_fun=110011, branch=1, reg_write=0. `bgtz` → alu_fun=111111, B=0.
- Stall asserted for 3 cycles with changing `instr` → outputs frozen. Stall and flush asserted together → valid=0. `add $0,...` → reg_write=0.
- Opcode 0x3F → illegal=1, valid=1, reg_write=0. Reset asserted mid-stall → all outputs 0 on the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALUFun codes, MIPS opcode/funct constants, the decoded control bundle
// and the immediate-extension helper used by the issue stage.
package alu_pkg;

  localparam int DW = 32;

  localparam logic [5:0] FUN_ADD   = 6'b000000;
  localparam logic [5:0] FUN_SUB   = 6'b000001;
  localparam logic [5:0] FUN_AND   = 6'b011000;
  localparam logic [5:0] FUN_OR    = 6'b011110;
  localparam logic [5:0] FUN_XOR   = 6'b010110;
  localparam logic [5:0] FUN_NOR   = 6'b010001;
  localparam logic [5:0] FUN_PASSA = 6'b011010;
  localparam logic [5:0] FUN_SLL   = 6'b100000;
  localparam logic [5:0] FUN_SRL   = 6'b100001;
  localparam logic [5:0] FUN_SRA   = 6'b100011;
  localparam logic [5:0] FUN_EQ    = 6'b110011;
  localparam logic [5:0] FUN_NEQ   = 6'b110001;
  localparam logic [5:0] FUN_LT    = 6'b110101;
  localparam logic [5:0] FUN_LEZ   = 6'b111101;
  localparam logic [5:0] FUN_LTZ   = 6'b111011;
  localparam logic [5:0] FUN_GTZ   = 6'b111111;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_SLLV   = 6'h04;
  localparam logic [5:0] FN_SRLV   = 6'h06;
  localparam logic [5:0] FN_SRAV   = 6'h07;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUB    = 6'h22;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_XOR    = 6'h26;
  localparam logic [5:0] FN_NOR    = 6'h27;
  localparam logic [5:0] FN_SLT    = 6'h2A;
  localparam logic [5:0] FN_SLTU   = 6'h2B;

  typedef struct packed {
    logic [5:0]    alu_fun;
    logic          sign;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    wr_reg;
    logic          reg_write;
    logic          branch;
    logic          illegal;
  } dec_t;

  function automatic logic [DW-1:0] ext16(input logic [15:0] imm, input logic sext);
    return sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
  endfunction

endpackage

// File: rtl/alu_fun_decoder.sv
// Combinational decode of one MIPS instruction into the ALU control and
// operand bundle; nothing here is registered.
module alu_fun_decoder
  import alu_pkg::*;
(
  input  logic [DW-1:0] instr_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  output dec_t          dec_o
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        bad;
  dec_t        dec;

  assign op    = instr_i[31:26];
  assign rt    = instr_i[20:16];
  assign rd    = instr_i[15:11];
  assign shamt = instr_i[10:6];
  assign fn    = instr_i[5:0];
  assign imm   = instr_i[15:0];

  always_comb begin
    dec         = '0;
    bad         = 1'b0;
    dec.a       = rs_data_i;
    dec.reg_write = 1'b1;
    if (op == OP_RTYPE) begin
      dec.wr_reg = rd;
      dec.b      = rt_data_i;
      case (fn)
        FN_ADD:  begin dec.alu_fun = FUN_ADD; dec.sign = 1'b1; end
        FN_ADDU: dec.alu_fun = FUN_ADD;
        FN_SUB:  begin dec.alu_fun = FUN_SUB; dec.sign = 1'b1; end
        FN_SUBU: dec.alu_fun = FUN_SUB;
        FN_AND:  dec.alu_fun = FUN_AND;
        FN_OR:   dec.alu_fun = FUN_OR;
        FN_XOR:  dec.alu_fun = FUN_XOR;
        FN_NOR:  dec.alu_fun = FUN_NOR;
        FN_SLT:  begin dec.alu_fun = FUN_LT; dec.sign = 1'b1; end
        FN_SLTU: dec.alu_fun = FUN_LT;
        FN_SLL:  begin dec.alu_fun = FUN_SLL; dec.a = {27'b0, shamt}; end
        FN_SRL:  begin dec.alu_fun = FUN_SRL; dec.a = {27'b0, shamt}; end
        FN_SRA:  begin dec.alu_fun = FUN_SRA; dec.a = {27'b0, shamt}; end
        FN_SLLV: begin dec.alu_fun = FUN_SLL; dec.a = {27'b0, rs_data_i[4:0]}; end
        FN_SRLV: begin dec.alu_fun = FUN_SRL; dec.a = {27'b0, rs_data_i[4:0]}; end
        FN_SRAV: begin dec.alu_fun = FUN_SRA; dec.a = {27'b0, rs_data_i[4:0]}; end
        default: bad = 1'b1;
      endcase
    end else begin
      dec.wr_reg = rt;
      case (op)
        OP_ADDI:  begin dec.alu_fun = FUN_ADD; dec.sign = 1'b1; dec.b = ext16(imm, 1'b1); end
        OP_ADDIU: begin dec.alu_fun = FUN_ADD; dec.b = ext16(imm, 1'b1); end
        OP_SLTI:  begin dec.alu_fun = FUN_LT; dec.sign = 1'b1; dec.b = ext16(imm, 1'b1); end
        OP_SLTIU: begin dec.alu_fun = FUN_LT; dec.b = ext16(imm, 1'b1); end
        OP_ANDI:  begin dec.alu_fun = FUN_AND; dec.b = ext16(imm, 1'b0); end
        OP_ORI:   begin dec.alu_fun = FUN_OR; dec.b = ext16(imm, 1'b0); end
        OP_XORI:  begin dec.alu_fun = FUN_XOR; dec.b = ext16(imm, 1'b0); end
        OP_LUI:   begin dec.alu_fun = FUN_SLL; dec.a = 32'd16; dec.b = ext16(imm, 1'b0); end
        OP_LW:    begin dec.alu_fun = FUN_ADD; dec.sign = 1'b1; dec.b = ext16(imm, 1'b1); end
        OP_SW: begin
          dec.alu_fun = FUN_ADD; dec.sign = 1'b1; dec.b = ext16(imm, 1'b1);
          dec.reg_write = 1'b0;
        end
        // Branches compare rs against rt or against zero; B stays 0 for the zero forms.
        OP_BEQ:  begin dec.alu_fun = FUN_EQ;  dec.b = rt_data_i; dec.branch = 1'b1; end
        OP_BNE:  begin dec.alu_fun = FUN_NEQ; dec.b = rt_data_i; dec.branch = 1'b1; end
        OP_BLEZ: begin dec.alu_fun = FUN_LEZ; dec.branch = 1'b1; end
        OP_BGTZ: begin dec.alu_fun = FUN_GTZ; dec.branch = 1'b1; end
        OP_REGIMM: begin
          if (rt == 5'd0) begin
            dec.alu_fun = FUN_LTZ;
            dec.branch  = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
        default: bad = 1'b1;
      endcase
      if (dec.branch) begin
        dec.sign      = 1'b1;
        dec.reg_write = 1'b0;
      end
    end
    if (dec.wr_reg == 5'd0) dec.reg_write = 1'b0;
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign dec_o = dec;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX boundary for the ALU: registers the decoded bundle with
// reset > flush > stall > load priority; an empty slot loads as a bubble.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [5:0]      ex_alu_fun,
  output logic            ex_sign,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_wr_reg,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_illegal
);

  dec_t dec;
  dec_t ex_d, ex_q;
  logic valid_d, valid_q;

  alu_fun_decoder u_dec (
    .instr_i   (instr),
    .rs_data_i (rs_data),
    .rt_data_i (rt_data),
    .dec_o     (dec)
  );

  always_comb begin
    valid_d = valid_q;
    ex_d    = ex_q;
    if (flush || (!stall && !in_valid)) begin
      valid_d = 1'b0;
      ex_d    = '0;
    end else if (!stall) begin
      valid_d = 1'b1;
      ex_d    = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ex_q    <= ex_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_alu_fun   = ex_q.alu_fun;
  assign ex_sign      = ex_q.sign;
  assign ex_a         = ex_q.a;
  assign ex_b         = ex_q.b;
  assign ex_wr_reg    = ex_q.wr_reg;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_branch    = ex_q.branch;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: mnemonic-level reference model checked every
// cycle, plus directed literal expectations for the listed scenarios.
module tb_alu_issue_stage;

  typedef struct packed {
    logic        v;
    logic [5:0]  fun;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wr;
    logic        rw;
    logic        br;
    logic        il;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [31:0] instr, rs_data, rt_data;
  logic        ex_valid, ex_sign, ex_reg_write, ex_branch, ex_illegal;
  logic [5:0]  ex_alu_fun;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_wr_reg;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_fun(ex_alu_fun), .ex_sign(ex_sign),
    .ex_a(ex_a), .ex_b(ex_b), .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic string mnem(input logic [31:0] ins);
    int op, fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    if (op == 0) begin
      case (fn)
        0: return "sll";   2: return "srl";   3: return "sra";
        4: return "sllv";  6: return "srlv";  7: return "srav";
        32: return "add";  33: return "addu"; 34: return "sub"; 35: return "subu";
        36: return "and";  37: return "or";   38: return "xor"; 39: return "nor";
        42: return "slt";  43: return "sltu";
        default: return "ill";
      endcase
    end
    if (op == 1) return (ins[20:16] == 5'd0) ? "bltz" : "ill";
    case (op)
      4: return "beq";    5: return "bne";   6: return "blez";  7: return "bgtz";
      8: return "addi";   9: return "addiu"; 10: return "slti"; 11: return "sltiu";
      12: return "andi";  13: return "ori";  14: return "xori"; 15: return "lui";
      35: return "lw";    43: return "sw";
      default: return "ill";
    endcase
  endfunction

  function automatic exp_t mk(input logic [5:0] fun, input logic sg, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] wr, input logic rw,
                              input logic br, input logic il);
    exp_t e;
    e.v = 1'b1; e.fun = fun; e.sg = sg; e.a = a; e.b = b; e.wr = wr;
    e.rw = rw && (wr != 5'd0); e.br = br; e.il = il;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    logic [4:0]  f_rt, f_rd;
    logic [31:0] sh, rsh, sx, zx;
    f_rt = ins[20:16];
    f_rd = ins[15:11];
    sh   = 32'(ins[10:6]);
    rsh  = rs % 32;
    sx   = 32'($signed(ins[15:0]));
    zx   = 32'(ins[15:0]);
    case (mnem(ins))
      "add":   return mk(6'b000000, 1, rs, rt, f_rd, 1, 0, 0);
      "addu":  return mk(6'b000000, 0, rs, rt, f_rd, 1, 0, 0);
      "sub":   return mk(6'b000001, 1, rs, rt, f_rd, 1, 0, 0);
      "subu":  return mk(6'b000001, 0, rs, rt, f_rd, 1, 0, 0);
      "and":   return mk(6'b011000, 0, rs, rt, f_rd, 1, 0, 0);
      "or":    return mk(6'b011110, 0, rs, rt, f_rd, 1, 0, 0);
      "xor":   return mk(6'b010110, 0, rs, rt, f_rd, 1, 0, 0);
      "nor":   return mk(6'b010001, 0, rs, rt, f_rd, 1, 0, 0);
      "slt":   return mk(6'b110101, 1, rs, rt, f_rd, 1, 0, 0);
      "sltu":  return mk(6'b110101, 0, rs, rt, f_rd, 1, 0, 0);
      "sll":   return mk(6'b100000, 0, sh, rt, f_rd, 1, 0, 0);
      "srl":   return mk(6'b100001, 0, sh, rt, f_rd, 1, 0, 0);
      "sra":   return mk(6'b100011, 0, sh, rt, f_rd, 1, 0, 0);
      "sllv":  return mk(6'b100000, 0, rsh, rt, f_rd, 1, 0, 0);
      "srlv":  return mk(6'b100001, 0, rsh, rt, f_rd, 1, 0, 0);
      "srav":  return mk(6'b100011, 0, rsh, rt, f_rd, 1, 0, 0);
      "addi":  return mk(6'b000000, 1, rs, sx, f_rt, 1, 0, 0);
      "addiu": return mk(6'b000000, 0, rs, sx, f_rt, 1, 0, 0);
      "slti":  return mk(6'b110101, 1, rs, sx, f_rt, 1, 0, 0);
      "sltiu": return mk(6'b110101, 0, rs, sx, f_rt, 1, 0, 0);
      "andi":  return mk(6'b011000, 0, rs, zx, f_rt, 1, 0, 0);
      "ori":   return mk(6'b011110, 0, rs, zx, f_rt, 1, 0, 0);
      "xori":  return mk(6'b010110, 0, rs, zx, f_rt, 1, 0, 0);
      "lui":   return mk(6'b100000, 0, 32'd16, zx, f_rt, 1, 0, 0);
      "lw":    return mk(6'b000000, 1, rs, sx, f_rt, 1, 0, 0);
      "sw":    return mk(6'b000000, 1, rs, sx, f_rt, 0, 0, 0);
      "beq":   return mk(6'b110011, 1, rs, rt, f_rt, 0, 1, 0);
      "bne":   return mk(6'b110001, 1, rs, rt, f_rt, 0, 1, 0);
      "blez":  return mk(6'b111101, 1, rs, 0, f_rt, 0, 1, 0);
      "bgtz":  return mk(6'b111111, 1, rs, 0, f_rt, 0, 1, 0);
      "bltz":  return mk(6'b111011, 1, rs, 0, f_rt, 0, 1, 0);
      default: return mk(6'b000000, 0, 0, 0, 5'd0, 0, 0, 1);
    endcase
  endfunction

  exp_t exp_s = '0;
  logic model_live = 1'b0;

  always @(posedge clk) begin
    if (reset || flush)     exp_s = '0;
    else if (stall)         exp_s = exp_s;
    else if (!in_valid)     exp_s = '0;
    else                    exp_s = model(instr, rs_data, rt_data);
    model_live = 1'b1;
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_live) begin
      chk("m_valid",     32'(ex_valid),     32'(exp_s.v));
      chk("m_alu_fun",   32'(ex_alu_fun),   32'(exp_s.fun));
      chk("m_sign",      32'(ex_sign),      32'(exp_s.sg));
      chk("m_a",         ex_a,              exp_s.a);
      chk("m_b",         ex_b,              exp_s.b);
      chk("m_wr_reg",    32'(ex_wr_reg),    32'(exp_s.wr));
      chk("m_reg_write", 32'(ex_reg_write), 32'(exp_s.rw));
      chk("m_branch",    32'(ex_branch),    32'(exp_s.br));
      chk("m_illegal",   32'(ex_illegal),   32'(exp_s.il));
    end
  end

  // ---------------- driver ----------------
  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input int sa, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sa), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                     input logic [31:0] rt, input logic st, input logic fl, input logic rst);
    in_valid = v; instr = ins; rs_data = rs; rt_data = rt;
    stall = st; flush = fl; reset = rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    cyc(1'b1, ins, rs, rt, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    in_valid = 0; instr = 0; rs_data = 0; rt_data = 0;
    stall = 0; flush = 0; reset = 1;

    cyc(1, r_ins(1, 2, 3, 0, 34), 32'd9, 32'd9, 0, 0, 1);
    cyc(1, r_ins(1, 2, 3, 0, 34), 32'd9, 32'd9, 0, 0, 1);
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_fun", 32'(ex_alu_fun), 0);
    chk("rst_b", ex_b, 0);

    load(r_ins(1, 2, 3, 0, 34), 32'd5, 32'd7);  // sub $3,$1,$2
    chk("sub_fun", 32'(ex_alu_fun), 32'b000001);
    chk("sub_sign", 32'(ex_sign), 1);
    chk("sub_a", ex_a, 5);
    chk("sub_b", ex_b, 7);
    chk("sub_wr", 32'(ex_wr_reg), 3);
    chk("sub_rw", 32'(ex_reg_write), 1);
    chk("sub_valid", 32'(ex_valid), 1);

    load(r_ins(0, 5, 4, 3, 3), 32'hDEAD_BEEF, 32'h8000_0000);  // sra $4,$5,3
    chk("sra_fun", 32'(ex_alu_fun), 32'b100011);
    chk("sra_a", ex_a, 3);
    chk("sra_b", ex_b, 32'h8000_0000);

    load(i_ins(15, 0, 6, 16'h1234), 32'h1111_1111, 32'h2222_2222);  // lui
    chk("lui_fun", 32'(ex_alu_fun), 32'b100000);
    chk("lui_a", ex_a, 16);
    chk("lui_b", ex_b, 32'h0000_1234);

    load(i_ins(11, 1, 2, 16'hFFFF), 32'd4, 32'd0);  // sltiu $2,$1,-1
    chk("sltiu_fun", 32'(ex_alu_fun), 32'b110101);
    chk("sltiu_sign", 32'(ex_sign), 0);
    chk("sltiu_b", ex_b, 32'hFFFF_FFFF);

    load(i_ins(12, 1, 7, 16'h8000), 32'd4, 32'd0);  // andi
    chk("andi_b", ex_b, 32'h0000_8000);

    load(i_ins(4, 1, 2, 5), 32'd10, 32'd10);  // beq
    chk("beq_fun", 32'(ex_alu_fun), 32'b110011);
    chk("beq_branch", 32'(ex_branch), 1);
    chk("beq_rw", 32'(ex_reg_write), 0);

    load(i_ins(7, 1, 0, 3), 32'd10, 32'd99);  // bgtz
    chk("bgtz_fun", 32'(ex_alu_fun), 32'b111111);
    chk("bgtz_b", ex_b, 0);

    load(i_ins(1, 3, 0, 8), 32'hFFFF_FFF0, 32'd1);   // bltz
    load(r_ins(1, 2, 3, 0, 4), 32'h25, 32'h0F);      // sllv
    chk("sllv_a", ex_a, 5);
    load(i_ins(35, 4, 9, 16'hFFFC), 32'd100, 32'd0); // lw
    load(i_ins(43, 4, 9, 16'h0010), 32'd100, 32'd0); // sw
    chk("sw_rw", 32'(ex_reg_write), 0);
    load(r_ins(8, 9, 10, 0, 39), 32'hF0F0_0000, 32'h0000_0F0F);  // nor

    load(r_ins(1, 2, 3, 0, 34), 32'd5, 32'd7);
    for (int i = 0; i < 3; i++) begin
      cyc(1, r_ins(i, i + 1, 12, 0, 32) ^ 32'(i * 7), 32'(i), 32'(i + 100), 1, 0, 0);
      chk("stall_fun", 32'(ex_alu_fun), 32'b000001);
      chk("stall_a", ex_a, 5);
      chk("stall_valid", 32'(ex_valid), 1);
    end
    cyc(1, r_ins(1, 2, 3, 0, 32), 32'd1, 32'd1, 1, 1, 0);
    chk("stflush_valid", 32'(ex_valid), 0);

    load(r_ins(1, 2, 0, 0, 32), 32'd3, 32'd4);  // add $0
    chk("r0_rw", 32'(ex_reg_write), 0);
    chk("r0_valid", 32'(ex_valid), 1);

    load(32'hFC00_0000, 32'd3, 32'd4);  // opcode 0x3F
    chk("ill_il", 32'(ex_illegal), 1);
    chk("ill_valid", 32'(ex_valid), 1);
    chk("ill_rw", 32'(ex_reg_write), 0);

    cyc(0, r_ins(1, 2, 3, 0, 32), 32'd3, 32'd4, 0, 0, 0);
    chk("bubble_valid", 32'(ex_valid), 0);

    load(i_ins(5, 1, 2, 1), 32'd6, 32'd7);  // bne
    cyc(1, i_ins(8, 1, 2, 1), 32'd6, 32'd7, 1, 0, 0);
    cyc(1, i_ins(8, 1, 2, 1), 32'd6, 32'd7, 1, 0, 1);
    chk("rststall_valid", 32'(ex_valid), 0);
    chk("rststall_fun", 32'(ex_alu_fun), 0);
    chk("rststall_a", ex_a, 0);
    chk("rststall_branch", 32'(ex_branch), 0);

    cyc(0, 32'd0, 32'd0, 32'd0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
